// File: rtl/div_unit_if.sv
// Handshake/result bundle between the execute stage and the sequential divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             result_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             exception;

  modport master (
    output start, dividend, divisor,
    input  busy, result_ready, quotient, remainder, exception
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, result_ready, quotient, remainder, exception
  );
endinterface

// File: rtl/div_unit.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// sign-corrected on entry to DONE. Divide-by-zero and MIN/-1 finish in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic   clock,
  input logic   resetn,
  div_unit_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one trial subtraction per cycle, WIDTH steps
  // DONE  | results presented, result_ready pulse
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_diff_q;
  logic             dvd_neg_q;
  logic             busy_q;
  logic             ready_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             exc_q;

  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic             div_zero_d;
  logic             ovf_d;
  logic [WIDTH+1:0] shifted_d;
  logic             ge_d;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] quot_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  // -MIN_NEG wraps to itself, which is exactly its unsigned magnitude
  always_comb begin
    dvd_mag_d  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_mag_d  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    div_zero_d = (bus.divisor == '0);
    ovf_d      = (bus.dividend == MIN_NEG) && (bus.divisor == '1);

    shifted_d  = {r_q, q_q[WIDTH-1]};
    ge_d       = (shifted_d >= {2'b00, dvs_q});
    r_d        = ge_d ? (shifted_d[WIDTH:0] - {1'b0, dvs_q}) : shifted_d[WIDTH:0];
    q_d        = {q_q[WIDTH-2:0], ge_d};

    quot_fix_d = sign_diff_q ? -q_d : q_d;
    rem_fix_d  = dvd_neg_q ? -r_d[WIDTH-1:0] : r_d[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      sign_diff_q <= 1'b0;
      dvd_neg_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      exc_q       <= 1'b0;
    end else if (bus.start) begin
      // start in any state reloads; an aborted run never reaches DONE
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= dvd_mag_d;
      dvs_q       <= dvs_mag_d;
      sign_diff_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      dvd_neg_q   <= bus.dividend[WIDTH-1];
      busy_q      <= 1'b1;
      if (div_zero_d || ovf_d) begin
        state_q <= DONE;
        ready_q <= 1'b1;
        quot_q  <= div_zero_d ? '0 : MIN_NEG;
        rem_q   <= '0;
        exc_q   <= 1'b1;
      end else begin
        state_q <= RUN;
        ready_q <= 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            quot_q  <= quot_fix_d;
            rem_q   <= rem_fix_d;
            exc_q   <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_ready = ready_q;
  assign bus.quotient     = quot_q;
  assign bus.remainder    = rem_q;
  assign bus.exception    = exc_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, a negedge
// monitor pops and compares whenever result_ready is seen.
module tb_div_unit;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clock;
  logic resetn;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          lat;
    int          e0;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } vec_t;

  exp_t sb[$];

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetn && bus.result_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("quotient", bus.quotient, x.q);
        chk("remainder", bus.remainder, x.r);
        chk("exception", {31'd0, bus.exception}, {31'd0, x.e});
        chk("latency", 32'(cyc - x.e0), 32'(x.lat));
      end
    end
  end

  // Called at a negedge; returns 1 time unit after the sampling edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic ee, input bit push);
    exp_t x;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) begin
      x.q = eq; x.r = er; x.e = ee; x.lat = ee ? 1 : 33; x.e0 = cyc;
      sb.push_back(x);
    end
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.result_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.result_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
    end else if (a == MIN_NEG && b == 32'hFFFF_FFFF) begin
      q = MIN_NEG; r = 32'd0; e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      e = 1'b0;
    end
  endtask

  vec_t dir[10];

  initial begin
    dir[0] = '{32'd100,          32'd7,          32'd14,          32'd2,          1'b0};
    dir[1] = '{-32'sd100,        32'd7,          -32'sd14,        -32'sd2,        1'b0};
    dir[2] = '{32'd100,          -32'sd7,        -32'sd14,        32'd2,          1'b0};
    dir[3] = '{-32'sd100,        -32'sd7,        32'd14,          -32'sd2,        1'b0};
    dir[4] = '{32'h8000_0000,    32'd1,          32'h8000_0000,   32'd0,          1'b0};
    dir[5] = '{32'h7FFF_FFFF,    32'h7FFF_FFFF,  32'd1,           32'd0,          1'b0};
    dir[6] = '{32'd5,            32'd9,          32'd0,           32'd5,          1'b0};
    dir[7] = '{32'd0,            -32'sd3,        32'd0,           32'd0,          1'b0};
    dir[8] = '{32'd42,           32'd0,          32'd0,           32'd0,          1'b1};
    dir[9] = '{32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,   32'd0,          1'b1};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, q, r;
    logic        e;
    int          mode;

    resetn = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ready", {31'd0, bus.result_ready}, 32'd0);
    chk("rst_quot", bus.quotient, 32'd0);
    chk("rst_rem", bus.remainder, 32'd0);
    chk("rst_exc", {31'd0, bus.exception}, 32'd0);
    resetn = 1'b1;

    // asynchronous reset in the middle of a run
    @(negedge clock);
    issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);
    #2;
    chk("run_busy", {31'd0, bus.busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_quot", bus.quotient, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    foreach (dir[i]) begin
      wait_idle();
      issue(dir[i].a, dir[i].b, dir[i].q, dir[i].r, dir[i].e, 1'b1);
    end

    // abort: only the second operation completes; prior results hold meanwhile
    wait_idle();
    issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clock);
    chk("hold_quot", bus.quotient, MIN_NEG);
    chk("hold_exc", {31'd0, bus.exception}, 32'd1);
    issue(32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b1);
    repeat (20) @(negedge clock);
    chk("hold_ready", {31'd0, bus.result_ready}, 32'd0);
    chk("hold_quot2", bus.quotient, MIN_NEG);

    // random pairs; odd ones restart on the DONE cycle
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) b = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
      else if (mode == 2) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
      else if (mode == 3) a = 32'($signed(a) >>> $urandom_range(8, 30));
      ref_div(a, b, q, r, e);
      if (i % 2 == 1) wait_ready();
      else wait_idle();
      issue(a, b, q, r, e, 1'b1);
    end

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    chk("drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
